change_sequencer: RTL and testbench

CHANGE_SEQUENCER -- requirements
Module: change_sequencer

---
 rtl/change_sequencer.sv | 172 +++++++++++++++++
 tb/tb_change_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : change_sequencer
// Description : Vending-machine change sequencer. Accepts coins and item
//               selections while idle/active, times out after a quiet
//               period (or on user request) and returns the remaining total
//               one coin per cycle, largest coin first. The running total is
//               held downstream and fed back on current_total.
// Revision    : 1.0 - initial release
// ============================================================================
module change_sequencer #(
  parameter int kNumItems  = 4,
  parameter int kNumCoins  = 3,
  parameter int kTotalBits = 31,
  parameter int kWaitTime  = 10,
  parameter logic [kNumCoins-1:0][kTotalBits-1:0] kCoinValue =
    {31'd1000, 31'd500, 31'd100},
  parameter logic [kNumItems-1:0][kTotalBits-1:0] kItemPrice =
    {31'd2000, 31'd1000, 31'd500, 31'd400}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [kNumCoins-1:0]  i_input_coin,
  input  logic [kNumItems-1:0]  i_select_item,
  input  logic                  i_trigger_return,
  input  logic [kTotalBits-1:0] current_total,
  output logic [kNumItems-1:0]  available_item_1,
  output logic [kNumItems-1:0]  output_item_nxt,
  output logic [kNumCoins-1:0]  return_coin_1,
  output logic [kTotalBits-1:0] current_total_nxt,
  output logic                  return_changes
);

  // Wide enough to hold the total plus every coin inserted at once.
  localparam int c_SUM_BITS = kTotalBits + $clog2(kNumCoins + 1) + 1;
  localparam int c_CNT_BITS = $clog2(kWaitTime + 1);
  localparam logic [c_SUM_BITS-1:0] c_MAX_TOTAL =
    {{(c_SUM_BITS - kTotalBits){1'b0}}, {kTotalBits{1'b1}}};
  localparam logic [c_CNT_BITS-1:0] c_WAIT_LOAD = c_CNT_BITS'(kWaitTime);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    RETURNING = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [c_CNT_BITS-1:0]   wait_cnt_q, wait_cnt_d;

  logic [c_SUM_BITS-1:0]   coin_sum_raw;
  logic [c_SUM_BITS-1:0]   total_raw;
  logic                    coin_ok;
  logic                    coins_in;
  logic [kTotalBits-1:0]   total_in;

  logic                    sel_valid;
  logic [kNumItems-1:0]    sel_onehot;
  logic [kTotalBits-1:0]   sel_price;

  logic                    ret_valid;
  logic [kNumCoins-1:0]    ret_onehot;
  logic [kTotalBits-1:0]   ret_value;

  logic                    activity;

  // Availability display compares each price against the registered total.
  always_comb begin
    available_item_1 = '0;
    for (int i = 0; i < kNumItems; i++) begin
      available_item_1[i] = (current_total >= kItemPrice[i]);
    end
  end

  // Sum inserted coins; the whole cycle's coins are dropped if the total would overflow.
  always_comb begin
    coin_sum_raw = '0;
    for (int j = 0; j < kNumCoins; j++) begin
      if (i_input_coin[j]) begin
        coin_sum_raw = coin_sum_raw + c_SUM_BITS'(kCoinValue[j]);
      end
    end
    total_raw = c_SUM_BITS'(current_total) + coin_sum_raw;
    coin_ok   = (total_raw <= c_MAX_TOTAL);
    coins_in  = coin_ok && (coin_sum_raw != '0);
    total_in  = coin_ok ? total_raw[kTotalBits-1:0] : current_total;
  end

  // Pick the lowest-index requested item that the credit (including this cycle's coins) covers.
  always_comb begin
    sel_valid  = 1'b0;
    sel_onehot = '0;
    sel_price  = '0;
    for (int i = 0; i < kNumItems; i++) begin
      if (!sel_valid && i_select_item[i] && (total_in >= kItemPrice[i])) begin
        sel_valid     = 1'b1;
        sel_onehot[i] = 1'b1;
        sel_price     = kItemPrice[i];
      end
    end
  end

  // Greedy change: the largest coin value not exceeding the remaining total.
  always_comb begin
    ret_valid  = 1'b0;
    ret_onehot = '0;
    ret_value  = '0;
    for (int j = 0; j < kNumCoins; j++) begin
      if ((kCoinValue[j] <= current_total) &&
          (!ret_valid || (kCoinValue[j] > ret_value))) begin
        ret_valid     = 1'b1;
        ret_onehot    = '0;
        ret_onehot[j] = 1'b1;
        ret_value     = kCoinValue[j];
      end
    end
  end

  assign activity = coins_in || sel_valid;

  // Next-state, wait counter and output decode.
  always_comb begin
    state_d           = state_q;
    wait_cnt_d        = wait_cnt_q;
    output_item_nxt   = '0;
    return_coin_1     = '0;
    return_changes    = 1'b0;
    current_total_nxt = current_total;
    unique case (state_q)
      IDLE, ACTIVE: begin
        output_item_nxt   = sel_onehot;
        current_total_nxt = total_in - (sel_valid ? sel_price : '0);
        if (activity) begin
          wait_cnt_d = c_WAIT_LOAD;
          if (state_q == IDLE) begin
            state_d = ACTIVE;
          end
        end else if ((state_q == ACTIVE) && (wait_cnt_q != '0)) begin
          wait_cnt_d = wait_cnt_q - c_CNT_BITS'(1);
        end
        // Coins and selection above still take effect on the cycle we leave.
        if (i_trigger_return || ((state_q == ACTIVE) && (wait_cnt_q == '0))) begin
          state_d = RETURNING;
        end
      end
      RETURNING: begin
        return_changes = 1'b1;
        if (ret_valid) begin
          return_coin_1     = ret_onehot;
          current_total_nxt = current_total - ret_value;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and wait counter registers; reset clears them without waiting for clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_change_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_sequencer
// Description : Self-checking bench for change_sequencer. Directed scenarios
//               plus random coin/selection/trigger traffic, compared against
//               a behavioural vending model; the bench owns the downstream
//               total register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_sequencer;

  localparam int     NI   = 4;
  localparam int     NC   = 3;
  localparam int     WT   = 10;
  localparam longint MAXT = 64'h7FFF_FFFF;

  longint coin_val [0:NC-1] = '{100, 500, 1000};
  longint price    [0:NI-1] = '{400, 500, 1000, 2000};

  logic          clk;
  logic          reset;
  logic [NC-1:0] coin;
  logic [NI-1:0] sel;
  logic          trig;
  logic [30:0]   cur_total;
  logic [NI-1:0] avail;
  logic [NI-1:0] item;
  logic [NC-1:0] rcoin;
  logic [30:0]   nxt;
  logic          rc;

  int n_total = 0;
  int n_bad   = 0;

  // Behavioural model: returning flag, engaged flag and count of quiet cycles.
  bit     m_ret;
  bit     m_eng;
  int     m_quiet;
  longint e_nxt;
  bit     e_act;
  bit     e_done;

  change_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .i_input_coin     (coin),
    .i_select_item    (sel),
    .i_trigger_return (trig),
    .current_total    (cur_total),
    .available_item_1 (avail),
    .output_item_nxt  (item),
    .return_coin_1    (rcoin),
    .current_total_nxt(nxt),
    .return_changes   (rc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Apply inputs, let them settle, and compare every output against the model.
  task automatic run(input string tag, input logic [NC-1:0] c, input logic [NI-1:0] s,
                     input logic t);
    longint        tot, sum;
    int            selidx, best;
    logic [NI-1:0] e_av, e_item;
    logic [NC-1:0] e_coin;
    bit            e_rc;
    coin = c; sel = s; trig = t;
    #2;
    tot  = longint'(cur_total);
    e_av = '0; e_item = '0; e_coin = '0;
    for (int i = 0; i < NI; i++) if (tot >= price[i]) e_av[i] = 1'b1;
    if (m_ret) begin
      best = -1;
      for (int j = 0; j < NC; j++)
        if (coin_val[j] <= tot && (best < 0 || coin_val[j] > coin_val[best])) best = j;
      e_done = (best < 0);
      if (best >= 0) begin
        e_coin[best] = 1'b1;
        e_nxt = tot - coin_val[best];
      end else begin
        e_nxt = tot;
      end
      e_rc  = 1'b1;
      e_act = 1'b0;
    end else begin
      sum = 0;
      for (int j = 0; j < NC; j++) if (c[j]) sum += coin_val[j];
      if (tot + sum > MAXT) sum = 0;
      selidx = -1;
      for (int i = 0; i < NI; i++)
        if (selidx < 0 && s[i] && tot + sum >= price[i]) selidx = i;
      if (selidx >= 0) e_item[selidx] = 1'b1;
      e_nxt  = tot + sum - ((selidx >= 0) ? price[selidx] : 0);
      e_act  = (sum != 0) || (selidx >= 0);
      e_rc   = 1'b0;
      e_done = 1'b0;
    end
    check_val({tag, ".avail"}, avail, e_av);
    check_val({tag, ".item"},  item,  e_item);
    check_val({tag, ".coin"},  rcoin, e_coin);
    check_val({tag, ".nxt"},   nxt,   e_nxt);
    check_val({tag, ".rc"},    rc,    e_rc);
  endtask

  // Clock edge: downstream register takes the model's next total, model advances.
  task automatic adv();
    bit timeout;
    @(posedge clk);
    #1;
    if (m_ret) begin
      if (e_done) begin
        m_ret = 1'b0;
        m_eng = 1'b0;
      end
    end else begin
      timeout = m_eng && (m_quiet >= WT);
      if (e_act) begin
        m_quiet = 0;
        m_eng   = 1'b1;
      end else if (m_eng) begin
        m_quiet++;
      end
      if (trig || timeout) m_ret = 1'b1;
    end
    cur_total = e_nxt[30:0];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    coin = '0; sel = '0; trig = 1'b0;
    cur_total = '0;
    m_ret = 1'b0; m_eng = 1'b0; m_quiet = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [NC-1:0] seq39 [0:2] = '{3'b100, 3'b010, 3'b001};
  logic [NC-1:0] rc_c;
  logic [NI-1:0] rc_s;
  logic          rc_t;

  initial begin
    reset = 1'b1;
    coin = '0; sel = '0; trig = 1'b0; cur_total = '0;
    m_ret = 1'b0; m_eng = 1'b0; m_quiet = 0;
    run("reset", 3'b000, 4'b0000, 1'b0);
    do_reset();

    // Two coins in one cycle.
    run("r37", 3'b110, 4'b0000, 1'b0);
    check_val("r37.sum", nxt, 1500);
    adv();
    // Selection at 1500, alone and with a concurrent 100 coin.
    run("r38a", 3'b000, 4'b1100, 1'b0);
    check_val("r38.avail", avail, 4'b0111);
    check_val("r38.item", item, 4'b0100);
    check_val("r38.nxt", nxt, 500);
    run("r38b", 3'b001, 4'b1100, 1'b0);
    check_val("r38.nxt_coin", nxt, 600);
    adv();
    // 1600 then trigger: greedy return 1000, 500, 100.
    run("r39c", 3'b100, 4'b0000, 1'b0);
    adv();
    run("r39t", 3'b000, 4'b0000, 1'b1);
    adv();
    for (int k = 0; k < 3; k++) begin
      run("r39r", 3'b111, 4'b1111, 1'b1);
      check_val("r39.seq", rcoin, seq39[k]);
      adv();
    end
    run("r39e", 3'b000, 4'b0000, 1'b0);
    check_val("r39.end_coin", rcoin, 3'b000);
    adv();
    run("r39i", 3'b000, 4'b0000, 1'b0);
    check_val("r39.idle_rc", rc, 1'b0);
    adv();

    // Trigger with nothing inserted: one RETURNING cycle then IDLE.
    run("r33t", 3'b000, 4'b0000, 1'b1);
    adv();
    run("r33r", 3'b000, 4'b0000, 1'b0);
    check_val("r33.rc", rc, 1'b1);
    adv();
    run("r33i", 3'b000, 4'b0000, 1'b0);
    adv();

    // Timeout: 400 inserted, return starts at the 11th edge after the last coin.
    for (int k = 0; k < 4; k++) begin
      run("r40c", 3'b001, 4'b0000, 1'b0);
      adv();
    end
    for (int k = 0; k < WT + 1; k++) begin
      run("r40q", 3'b000, 4'b0000, 1'b0);
      check_val("r40.quiet_rc", rc, 1'b0);
      adv();
    end
    for (int k = 0; k < 4; k++) begin
      run("r40r", 3'b000, 4'b0000, 1'b0);
      check_val("r40.coin", rcoin, 3'b001);
      adv();
    end
    run("r40e", 3'b000, 4'b0000, 1'b0);
    adv();
    run("r40i", 3'b000, 4'b0000, 1'b0);
    adv();

    // Overflow: coin ignored and the wait counter keeps running.
    run("r41a", 3'b001, 4'b0000, 1'b0);
    adv();
    cur_total = 31'h7FFF_FFFF - 31'd199;
    for (int k = 0; k < 4; k++) begin
      run("r41q", 3'b000, 4'b0000, 1'b0);
      adv();
    end
    run("r41o", 3'b100, 4'b0000, 1'b0);
    check_val("r41.nxt", nxt, 64'h7FFF_FFFF - 199);
    adv();
    for (int k = 0; k < 6; k++) begin
      run("r41w", 3'b000, 4'b0000, 1'b0);
      check_val("r41.wait_rc", rc, 1'b0);
      adv();
    end
    run("r41r", 3'b000, 4'b0000, 1'b0);
    check_val("r41.ret_rc", rc, 1'b1);
    check_val("r41.ret_coin", rcoin, 3'b100);
    adv();

    // Asynchronous reset in the middle of RETURNING.
    coin = '0; sel = '0; trig = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_val("r42.rc", rc, 1'b0);
    check_val("r42.coin", rcoin, 3'b000);
    check_val("r42.nxt", nxt, cur_total);
    coin = 3'b001;
    #1;
    check_val("r42.nxt_coin", nxt, longint'(cur_total) + 100);
    do_reset();

    // Random traffic with periodic quiet stretches to exercise the timeout.
    for (int n = 0; n < 400; n++) begin
      rc_c = '0; rc_s = '0; rc_t = 1'b0;
      if ((n % 60) < 46) begin
        if ($urandom_range(0, 3) == 0) rc_c = NC'($urandom_range(1, 7));
        if ($urandom_range(0, 2) == 0) rc_s = NI'($urandom_range(1, 15));
        rc_t = ($urandom_range(0, 39) == 0);
      end
      run("rnd", rc_c, rc_s, rc_t);
      adv();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
